// File: rtl/reg_pipe_hs_pkg.sv
// Shared constants and helpers for the reg_pipe_hs handshake pipeline.
// Optional parity storage is enabled with the REG_PIPE_HS_PARITY_EN macro.
`ifndef ANCHO
`define ANCHO 8
`endif
`ifndef PIPE_DEPTH_MAX
`define PIPE_DEPTH_MAX 16
`endif

package reg_pipe_hs_pkg;

  localparam int PIPE_DEPTH_MAX = `PIPE_DEPTH_MAX;
  localparam int PAR_W          = 64;

  // Even parity of a word zero-extended to PAR_W bits (extension does not change parity).
  function automatic logic word_parity(input logic [PAR_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: valid bit plus data word (plus parity with REG_PIPE_HS_PARITY_EN).
// Data only captures on a valid upstream load so empty slots keep their last contents.
module reg_pipe_stage
  import reg_pipe_hs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
`ifdef REG_PIPE_HS_PARITY_EN
  input  logic             up_par,
  output logic             par,
`endif
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  // Slot storage with flush and advance-gated load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      data  <= {WIDTH{1'b0}};
`ifdef REG_PIPE_HS_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (clear) begin
      valid <= 1'b0;
      data  <= {WIDTH{1'b0}};
`ifdef REG_PIPE_HS_PARITY_EN
      par   <= 1'b0;
`endif
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
`ifdef REG_PIPE_HS_PARITY_EN
        par  <= up_par;
`endif
      end
    end
  end

endmodule

// File: rtl/reg_pipe_hs.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush and occupancy count.
// Define REG_PIPE_HS_PARITY_EN to add per-stage parity, par_inject and parity_err.
`ifndef ANCHO
`define ANCHO 8
`endif
`ifndef PIPE_DEPTH_MAX
`define PIPE_DEPTH_MAX 16
`endif

module reg_pipe_hs
  import reg_pipe_hs_pkg::*;
#(
  parameter int WIDTH = `ANCHO,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef REG_PIPE_HS_PARITY_EN
  ,
  input  logic                       par_inject,
  output logic                       parity_err
`endif
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);

  if (DEPTH < 1 || DEPTH > `PIPE_DEPTH_MAX) begin : g_depth_check
    $error("reg_pipe_hs: DEPTH out of range");
  end

  logic [DEPTH-1:0] v_s;
  logic [DEPTH-1:0] adv_s;
  logic [WIDTH-1:0] d_s [DEPTH];
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [CW-1:0]    count_r;
`ifdef REG_PIPE_HS_PARITY_EN
  logic [DEPTH-1:0] p_s;
`endif

  // Advance chain: a slot may load when it is empty, its successor is empty, or its successor moves.
  always_comb begin
    adv_s = {DEPTH{1'b0}};
    adv_s[DEPTH-1] = out_ready | ~v_s[DEPTH-1];
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv_s[i] = ~v_s[i] | ~v_s[i+1] | adv_s[i+1];
    end
  end

  assign in_ready   = adv_s[0] & ~clear;
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = v_s[DEPTH-1] & out_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic             up_valid_s;
    logic [WIDTH-1:0] up_data_s;
`ifdef REG_PIPE_HS_PARITY_EN
    logic             up_par_s;
`endif
    if (g == 0) begin : g_head
      assign up_valid_s = in_xfer_s;
      assign up_data_s  = in_data;
`ifdef REG_PIPE_HS_PARITY_EN
      assign up_par_s   = word_parity(PAR_W'(in_data)) ^ par_inject;
`endif
    end else begin : g_body
      assign up_valid_s = v_s[g-1];
      assign up_data_s  = d_s[g-1];
`ifdef REG_PIPE_HS_PARITY_EN
      assign up_par_s   = p_s[g-1];
`endif
    end

    reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .load     (adv_s[g]),
      .up_valid (up_valid_s),
      .up_data  (up_data_s),
`ifdef REG_PIPE_HS_PARITY_EN
      .up_par   (up_par_s),
      .par      (p_s[g]),
`endif
      .valid    (v_s[g]),
      .data     (d_s[g])
    );
  end

  // Occupancy tracks transfers rather than summing valid bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {CW{1'b0}};
    end else if (clear) begin
      count_r <= {CW{1'b0}};
    end else begin
      case ({in_xfer_s, out_xfer_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign count     = count_r;
  assign out_valid = v_s[DEPTH-1];
  assign out_data  = v_s[DEPTH-1] ? d_s[DEPTH-1] : {WIDTH{1'b0}};
`ifdef REG_PIPE_HS_PARITY_EN
  assign parity_err = out_valid & (word_parity(PAR_W'(out_data)) != p_s[DEPTH-1]);
`endif

endmodule

// File: tb/tb_reg_pipe_hs.sv
// Self-checking bench for reg_pipe_hs (WIDTH=8, DEPTH=4) against a slot-position queue model.
// Parity scenarios are exercised when REG_PIPE_HS_PARITY_EN is defined.
module tb_reg_pipe_hs;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         reset_n;
  logic         clear;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [2:0]   count;
`ifdef REG_PIPE_HS_PARITY_EN
  logic         par_inject;
  logic         parity_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  reg_pipe_hs #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count)
`ifdef REG_PIPE_HS_PARITY_EN
    ,
    .par_inject (par_inject),
    .parity_err (parity_err)
`endif
  );

  always #5 clk = ~clk;

  // Model: words in FIFO order, each with its slot index (0 = input side, D-1 = output).
  logic [W-1:0] mq[$];
  int           mp[$];
  bit           mb[$];
  int           np[$];
  logic         e_ir, e_ov, e_perr;
  logic [W-1:0] e_od;
  int           e_cnt;

  task automatic predict();
    int prev, n, last;
    e_ov   = (mq.size() > 0) && (mp[0] == D - 1);
    e_od   = e_ov ? mq[0] : 8'h00;
    e_perr = e_ov && mb[0];
    e_cnt  = mq.size();
    np.delete();
    prev = D;
    for (int i = 0; i < mq.size(); i++) begin
      if (i == 0 && e_ov && out_ready) begin
        np.push_back(D);
      end else begin
        n = mp[i] + 1;
        if (n > prev - 1) n = prev - 1;
        np.push_back(n);
        prev = n;
      end
    end
    last = (np.size() == 0) ? D : np[np.size()-1];
    e_ir = (last >= 1) && !clear;
  endtask

  task automatic commit();
    bit inj;
    inj = 1'b0;
`ifdef REG_PIPE_HS_PARITY_EN
    inj = par_inject;
`endif
    if (clear) begin
      mq.delete(); mp.delete(); mb.delete();
    end else begin
      for (int i = 0; i < mp.size(); i++) mp[i] = np[i];
      if (e_ov && out_ready) begin
        void'(mq.pop_front()); void'(mp.pop_front()); void'(mb.pop_front());
      end
      if (in_valid && e_ir) begin
        mq.push_back(in_data); mp.push_back(0); mb.push_back(inj);
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; in_data = 8'h3C; out_ready = 1'b0; clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, out_data, count} !== {1'b0, 8'h00, 3'd0}) begin
        n_fail++;
        $display("FAIL reset c=%0d got ov=%b od=%h cnt=%0d want 0/00/0", c, out_valid, out_data, count);
      end
    end
    reset_n = 1'b1; in_valid = 1'b0;
    #2;
    n_checks++;
    if ({in_ready, out_valid, count} !== {1'b1, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_release got ir=%b ov=%b cnt=%0d want 1/0/0", in_ready, out_valid, count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    int first_ov;
    first_ov = -1;
    for (int c = 0; c < 8; c++) begin
      in_valid = (c == 0); in_data = 8'hA5; out_ready = 1'b1; clear = 1'b0;
      #2; predict();
      n_checks++;
      if ({in_ready, out_valid, out_data, count} !== {e_ir, e_ov, e_od, 3'(e_cnt)}) begin
        n_fail++;
        $display("FAIL latency c=%0d got ir=%b ov=%b od=%h cnt=%0d want ir=%b ov=%b od=%h cnt=%0d",
                 c, in_ready, out_valid, out_data, count, e_ir, e_ov, e_od, e_cnt);
      end
      if (out_valid && first_ov < 0) first_ov = c;
      if (c == 5) begin
        n_checks++;
        if (count !== 3'd0) begin
          n_fail++;
          $display("FAIL latency_count_after got %0d want 0", count);
        end
      end
      @(posedge clk); commit(); #1;
    end
    n_checks++;
    if (first_ov != 4) begin
      n_fail++;
      $display("FAIL latency_cycles got %0d want 4", first_ov);
    end
  endtask

  task automatic test_streaming();
    logic [W-1:0] got[$];
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 16); in_data = 8'(c); out_ready = 1'b1; clear = 1'b0;
      #2; predict();
      n_checks++;
      if ({in_ready, out_valid, out_data, count} !== {e_ir, e_ov, e_od, 3'(e_cnt)}) begin
        n_fail++;
        $display("FAIL stream c=%0d got ir=%b ov=%b od=%h cnt=%0d want ir=%b ov=%b od=%h cnt=%0d",
                 c, in_ready, out_valid, out_data, count, e_ir, e_ov, e_od, e_cnt);
      end
      if (c >= 4 && c < 16) begin
        n_checks++;
        if (count !== 3'd4 || out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_steady c=%0d got cnt=%0d ov=%b want 4/1", c, count, out_valid);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk); commit(); #1;
    end
    n_checks++;
    if (got.size() != 16) begin
      n_fail++;
      $display("FAIL stream_len got %0d want 16", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 8'(i)) begin
        n_fail++;
        $display("FAIL stream_order i=%0d got %h want %h", i, got[i], 8'(i));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] seq[5];
    logic [W-1:0] got[$];
    int idx;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready = (c >= 8); clear = 1'b0;
      in_valid  = (c != 1) && (idx < 5);
      in_data   = (idx < 5) ? seq[idx] : 8'h00;
      #2; predict();
      n_checks++;
      if ({in_ready, out_valid, out_data, count} !== {e_ir, e_ov, e_od, 3'(e_cnt)}) begin
        n_fail++;
        $display("FAIL backpressure c=%0d got ir=%b ov=%b od=%h cnt=%0d want ir=%b ov=%b od=%h cnt=%0d",
                 c, in_ready, out_valid, out_data, count, e_ir, e_ov, e_od, e_cnt);
      end
      if (c == 5) begin
        n_checks++;
        if ({in_ready, count} !== {1'b0, 3'd4}) begin
          n_fail++;
          $display("FAIL backpressure_full got ir=%b cnt=%0d want 0/4", in_ready, count);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && in_ready) idx++;
      @(posedge clk); commit(); #1;
    end
    n_checks++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL backpressure_len got %0d want 5", got.size());
    end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_checks++;
      if (got[i] !== seq[i]) begin
        n_fail++;
        $display("FAIL backpressure_order i=%0d got %h want %h", i, got[i], seq[i]);
      end
    end
  endtask

  task automatic test_clear();
    for (int c = 0; c < 7; c++) begin
      in_valid = (c <= 3); in_data = 8'(8'h61 + c); out_ready = 1'b0; clear = (c == 3);
      #2; predict();
      n_checks++;
      if ({in_ready, out_valid, out_data, count} !== {e_ir, e_ov, e_od, 3'(e_cnt)}) begin
        n_fail++;
        $display("FAIL clear c=%0d got ir=%b ov=%b od=%h cnt=%0d want ir=%b ov=%b od=%h cnt=%0d",
                 c, in_ready, out_valid, out_data, count, e_ir, e_ov, e_od, e_cnt);
      end
      if (c == 3) begin
        n_checks++;
        if (count !== 3'd3) begin
          n_fail++;
          $display("FAIL clear_pre got cnt=%0d want 3", count);
        end
      end
      if (c == 4) begin
        n_checks++;
        if ({count, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
          n_fail++;
          $display("FAIL clear_post got cnt=%0d ov=%b ir=%b want 0/0/1", count, out_valid, in_ready);
        end
      end
      @(posedge clk); commit(); #1;
    end
  endtask

`ifdef REG_PIPE_HS_PARITY_EN
  task automatic test_parity();
    for (int k = 0; k < 2; k++) begin
      int seen;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
        in_valid = (c == 0); in_data = 8'h0F; out_ready = 1'b1; clear = 1'b0;
        par_inject = (c == 0) && (k == 0);
        #2; predict();
        if (out_valid) begin
          seen++;
          n_checks++;
          if ({out_data, parity_err} !== {8'h0F, (k == 0)}) begin
            n_fail++;
            $display("FAIL parity k=%0d got od=%h perr=%b want 0f/%b", k, out_data, parity_err, (k == 0));
          end
        end
        @(posedge clk); commit(); #1;
      end
      par_inject = 1'b0;
      n_checks++;
      if (seen != 1) begin
        n_fail++;
        $display("FAIL parity_seen k=%0d got %0d want 1", k, seen);
      end
    end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      clear     = ($urandom_range(0, 29) == 0);
`ifdef REG_PIPE_HS_PARITY_EN
      par_inject = ($urandom_range(0, 3) == 0);
`endif
      #2; predict();
      n_checks++;
      if ({in_ready, out_valid, out_data, count} !== {e_ir, e_ov, e_od, 3'(e_cnt)}) begin
        n_fail++;
        $display("FAIL random c=%0d got ir=%b ov=%b od=%h cnt=%0d want ir=%b ov=%b od=%h cnt=%0d",
                 c, in_ready, out_valid, out_data, count, e_ir, e_ov, e_od, e_cnt);
      end
`ifdef REG_PIPE_HS_PARITY_EN
      n_checks++;
      if (parity_err !== e_perr) begin
        n_fail++;
        $display("FAIL random_parity c=%0d got %b want %b", c, parity_err, e_perr);
      end
`endif
      @(posedge clk); commit(); #1;
    end
    clear = 1'b0;
`ifdef REG_PIPE_HS_PARITY_EN
    par_inject = 1'b0;
`endif
  endtask

  task automatic test_async_reset();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 8'(8'hC0 + c); out_ready = 1'b0; clear = 1'b0;
      @(posedge clk); commit(); #1;
    end
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_data, count} !== {1'b0, 8'h00, 3'd0}) begin
      n_fail++;
      $display("FAIL async_reset got ov=%b od=%h cnt=%0d want 0/00/0", out_valid, out_data, count);
    end
    mq.delete(); mp.delete(); mb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    clk = 1'b0; reset_n = 1'b0; clear = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
`ifdef REG_PIPE_HS_PARITY_EN
    par_inject = 1'b0;
`endif
    #1;
    test_reset();
    test_latency();
    test_streaming();
    test_backpressure();
    test_clear();
`ifdef REG_PIPE_HS_PARITY_EN
    test_parity();
`endif
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_pipe_hs.md
Name: reg_pipe_hs

Overview:
- Parametrised multi-stage data pipeline register with valid/ready handshake, bubble collapsing, synchronous flush and occupancy count.
- Generalises the team's single-stage enable-gated D register to WIDTH bits and DEPTH stages with backpressure.
- Sits between producer and consumer datapaths that need fixed retiming plus flow control.

Parameters:
- WIDTH, default `ancho (8), data word width in bits.
- DEPTH, default 4, number of register stages; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush; empties all stages.
- in_valid  in  1  producer presents a word.
- in_ready  out  1  pipe can accept a word this cycle.
- in_data  in  WIDTH  input word.
- out_valid  out  1  last stage holds a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  WIDTH  last-stage word; forced to 0 when out_valid=0.
- count  out  $clog2(DEPTH+1)  number of occupied stages.

Behaviour:
- Storage: DEPTH stages, each with a valid bit v[i] and a data register d[i]. Stage 0 is the input side; stage DEPTH-1 drives out_*.
- Advance rule:
  - adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
  - adv[i] = ~v[i] | (v[i+1]==0) | adv[i+1] for i < DEPTH-1. Bubbles collapse: a word moves forward whenever the next stage is empty or moving.
- in_ready = adv[0] & ~clear. This is a combinational ripple from out_ready; no registered ready.
- Transfers:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- Per edge:
  - If clear=1: all v[i] are set to 0, all d[i] are set to 0, and in_valid is ignored. Clear has priority over every transfer.
  - Otherwise, each stage with adv[i]=1 loads from its upstream stage (stage 0 loads from the input). v[0] takes (in_valid & in_ready).
  - d[i] loads only on a valid upstream load and holds otherwise.
- Latency: a word accepted at edge t into an empty pipe with out_ready=1 appears on out_valid at edge t+DEPTH-1. That is DEPTH register stages, including the input stage.
- Throughput: one word per clock sustained while out_ready=1.
- count:
  - Registered; equals the sum of v[i] after each edge.
  - +1 on input-only transfer, -1 on output-only transfer, unchanged on both or neither.
  - Goes to 0 on clear.
- Full condition: count==DEPTH and out_ready=0 gives in_ready=0. If count==DEPTH and out_ready=1, in_ready=1 (simultaneous in/out is allowed).
- Empty condition: count==0 gives out_valid=0 and out_data=0.
- Ordering: strict FIFO order; no word is dropped or duplicated.
- Reset: while reset_n=0, all v, d and count are 0. Outputs are out_valid=0, out_data=0, count=0, and in_ready=1 once reset_n=1. Asserting reset mid-stream discards all content immediately, without waiting for a clock.
- DEPTH=1: the single stage behaves as a one-entry buffer with ready = out_ready | empty.

Optional Feature:
- Macro: REG_PIPE_HS_PARITY_EN.
- Enabled:
  - Each stage stores an extra parity bit p[i] = ^in_data, captured at input.
  - Extra output port parity_err (1 bit) = out_valid & (^out_data != p[DEPTH-1]), combinational.
  - Extra input port par_inject (1 bit): when it is 1 on an input transfer, the stored parity is inverted. Test use only.
  - clear and reset zero p[i].
- Disabled: no parity storage and no parity_err or par_inject ports. Behaviour is otherwise identical.

Decomposition:
- Shared constants stay in constantes.h (`ancho default width).
- Add `PIPE_DEPTH_MAX (16) to constantes.h for the parameter legality check.
- One natural sub-module: reg_pipe_stage. It is one valid+data(+parity) register with load/clear, and it is instantiated DEPTH times via generate.
- The advance chain and count logic live in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with in_valid=1 -> out_valid=0, out_data=0, count=0; after release, in_ready=1.
- Latency, DEPTH=4: single word 0xA5 accepted at edge t, out_ready=1 -> out_valid=1 with out_data=0xA5 after edge t+3; count returns 0 after the output transfer.
- Streaming: words 0x00..0x0F on consecutive cycles with out_ready=1 -> the same 16 words out in order, no gaps after fill, count stays at 4 during steady state.
- Backpressure and bubbles: out_ready=0, inputs 0x11 then idle then 0x22, 0x33, 0x44, 0x55 -> in_ready drops after 4 words (0x55 is held), count=4. Then out_ready=1 -> 0x11, 0x22, 0x33, 0x44, 0x55 out in order.
- Clear mid-stream: with count=3 and in_valid=1, pulse clear for 1 cycle -> next cycle count=0, out_valid=0, the concurrent input is not accepted, and in_ready=1 the cycle after.
- Parity, macro on: send 0x0F with par_inject=1 -> parity_err=1 while that word is at the output; send 0x0F normally -> parity_err=0.
